// File: rtl/out_channel_checker_pkg.sv
// Shared types and defaults for the output-channel checker.
package out_check_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } out_check_state_t;

   localparam int OUT_CHECK_WIDTH = 12;

endpackage

// File: rtl/out_channel_checker_if.sv
// Valid/ready stream carrying engine output words into the checker.
interface out_channel_checker_if
   import out_check_pkg::*;
#(
   parameter int Width = OUT_CHECK_WIDTH
);

   logic             outValid;
   logic [Width-1:0] outData;
   logic             outReady;

   modport master (output outValid, output outData, input outReady);
   modport slave  (input outValid, input outData, output outReady);

endinterface

// File: rtl/out_channel_checker_fifo.sv
// Synchronous FIFO buffering accepted output words ahead of the compare stage.
module out_fifo #(
   parameter  int Width = 12,
   parameter  int Depth = 4,
   localparam int AW    = $clog2(Depth),
   localparam int CW    = $clog2(Depth + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [Width-1:0] mem [Depth];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(Depth));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers wrap naturally since Depth is a power of two; count tells full from empty.
   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/out_channel_checker.sv
// Checks buffered engine output words in order against a loadable expected table.
module out_channel_checker
   import out_check_pkg::*;
#(
   parameter  int MemoryElementWidth = OUT_CHECK_WIDTH,
   parameter  int NOut               = 2,
   parameter  int FifoDepth          = 4,
   localparam int IW                 = (NOut > 1) ? $clog2(NOut) : 1,
   localparam int CW                 = $clog2(NOut + 1)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          expWrite,
   input  logic [IW-1:0]                 expIndex,
   input  logic [MemoryElementWidth-1:0] expData,
   input  logic [CW-1:0]                 expCount,
   input  logic                          start,
   out_channel_checker_if.slave          ch,
   input  logic                          progDone,
   output logic                          finished,
   output logic                          success,
   output logic [CW:0]                   received,
   output logic                          mismatch,
   output logic [CW:0]                   mismatchIndex
);

   localparam int            FCW    = $clog2(FifoDepth + 1);
   localparam logic [CW:0]   NOUT_L = (CW + 1)'(NOut);

   out_check_state_t              state;
   logic [MemoryElementWidth-1:0] tbl [NOut];
   logic [CW-1:0]                 count_q;
   logic [MemoryElementWidth-1:0] head;
   logic [FCW-1:0]                fcount;
   logic                          full;
   logic                          empty;
   logic                          push;
   logic                          pop;
   logic                          clear;
   logic                          bad;

   assign ch.outReady = (state == RUN) && !full;
   assign push        = ch.outValid && ch.outReady;
   assign pop         = !empty && ((state == RUN) || (state == DRAIN));
   assign clear       = start && ((state == IDLE) || (state == DONE));

   out_fifo #(
      .Width (MemoryElementWidth),
      .Depth (FifoDepth)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .push    (push),
      .pop     (pop),
      .wdata   (ch.outData),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (fcount)
   );

   // Positions past the table capacity count as overflow even if expCount claims more.
   always_comb begin
      bad = 1'b0;
      if ((received >= {1'b0, count_q}) || (received >= NOUT_L)) begin
         bad = 1'b1;
      end else if (head != tbl[received[IW-1:0]]) begin
         bad = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NOut; i++) tbl[i] <= '0;
      end else if (expWrite && (state == IDLE) && (int'(expIndex) < NOut)) begin
         tbl[expIndex] <= expData;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state         <= IDLE;
         count_q       <= '0;
         received      <= '0;
         mismatch      <= 1'b0;
         mismatchIndex <= '0;
         finished      <= 1'b0;
         success       <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state         <= RUN;
                  count_q       <= expCount;
                  received      <= '0;
                  mismatch      <= 1'b0;
                  mismatchIndex <= '0;
                  finished      <= 1'b0;
                  success       <= 1'b0;
               end
            end
            RUN: begin
               if (progDone) state <= DRAIN;
            end
            DRAIN: begin
               if (fcount == '0) begin
                  state    <= DONE;
                  finished <= 1'b1;
                  success  <= !mismatch && (received == {1'b0, count_q});
               end
            end
            default: state <= IDLE;
         endcase

         // Pops only happen in RUN/DRAIN, so they never collide with the start-time clears.
         if (pop) begin
            if (received != '1) received <= received + 1'b1;
            if (bad && !mismatch) begin
               mismatch      <= 1'b1;
               mismatchIndex <= received;
            end
         end
      end
   end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed scoreboard bench for out_channel_checker and its FIFO.
module tb_out_channel_checker;

   localparam int W = 12;

   typedef struct {
      logic       success;
      logic [4:0] rec;
      logic       mm;
      logic [4:0] idx;
   } res_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        expWrite = 1'b0;
   logic [2:0]  expIndex = '0;
   logic [W-1:0] expData = '0;
   logic [3:0]  expCount = '0;
   logic        start = 1'b0;
   logic        progDone = 1'b0;
   logic        finished;
   logic        success;
   logic [4:0]  received;
   logic        mismatch;
   logic [4:0]  mismatchIndex;

   logic         f_clear = 1'b0;
   logic         f_push = 1'b0;
   logic         f_pop = 1'b0;
   logic [W-1:0] f_wdata = '0;
   logic [W-1:0] f_rdata;
   logic         f_full;
   logic         f_empty;
   logic [2:0]   f_count;

   int   checks = 0;
   int   errors = 0;
   int   runs_done = 0;
   res_t exp_q[$];
   res_t cur;
   logic fin_q = 1'b0;

   always #5 clock = ~clock;

   out_channel_checker_if #(.Width(W)) ch ();

   out_channel_checker #(
      .MemoryElementWidth (W),
      .NOut               (8),
      .FifoDepth          (4)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .expWrite      (expWrite),
      .expIndex      (expIndex),
      .expData       (expData),
      .expCount      (expCount),
      .start         (start),
      .ch            (ch),
      .progDone      (progDone),
      .finished      (finished),
      .success       (success),
      .received      (received),
      .mismatch      (mismatch),
      .mismatchIndex (mismatchIndex)
   );

   out_fifo #(
      .Width (W),
      .Depth (4)
   ) fifo_u (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (f_clear),
      .push    (f_push),
      .pop     (f_pop),
      .wdata   (f_wdata),
      .rdata   (f_rdata),
      .full    (f_full),
      .empty   (f_empty),
      .count   (f_count)
   );

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
      end
   endtask

   // Result monitor: compares each completed run against the scoreboard queue.
   always @(negedge clock) begin
      if (reset_n && finished && !fin_q) begin
         runs_done++;
         if (exp_q.size() == 0) begin
            chk("unexpected_finish", 1, 0);
         end else begin
            cur = exp_q.pop_front();
            chk("success", int'(success), int'(cur.success));
            chk("received", int'(received), int'(cur.rec));
            chk("mismatch", int'(mismatch), int'(cur.mm));
            chk("mismatchIndex", int'(mismatchIndex), int'(cur.idx));
         end
      end
      fin_q = finished;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int idx, input int d);
      expWrite = 1'b1;
      expIndex = 3'(idx);
      expData  = W'(d);
      step();
      expWrite = 1'b0;
   endtask

   task automatic wait_finish(input string name);
      int t = 0;
      while (!finished && t < 20) begin
         step();
         t++;
      end
      if (!finished) chk(name, 0, 1);
      step();
   endtask

   task automatic do_run(input int cnt, input int w[4], input int n, input res_t e);
      exp_q.push_back(e);
      expCount = 4'(cnt);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         ch.outValid = 1'b1;
         ch.outData  = W'(w[i]);
         chk("outReady_run", int'(ch.outReady), 1);
         step();
      end
      ch.outValid = 1'b0;
      progDone = 1'b1;
      step();
      progDone = 1'b0;
      wait_finish("finish_timeout");
   endtask

   function automatic res_t mk(input int s, input int r, input int m, input int x);
      res_t v;
      v.success = 1'(s);
      v.rec     = 5'(r);
      v.mm      = 1'(m);
      v.idx     = 5'(x);
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      ch.outValid = 1'b0;
      ch.outData  = '0;
      step();
      step();
      chk("rst_outReady", int'(ch.outReady), 0);
      chk("rst_finished", int'(finished), 0);
      chk("rst_success", int'(success), 0);
      chk("rst_received", int'(received), 0);
      chk("rst_mismatch", int'(mismatch), 0);
      chk("rst_mismatchIndex", int'(mismatchIndex), 0);
      reset_n = 1'b1;
      step();

      wr(0, 3);
      wr(1, 5);

      do_run(2, '{3, 5, 0, 0}, 2, mk(1, 2, 0, 0));
      do_run(2, '{3, 6, 0, 0}, 2, mk(0, 2, 1, 1));
      do_run(2, '{3, 5, 7, 0}, 3, mk(0, 3, 1, 2));
      do_run(2, '{3, 0, 0, 0}, 1, mk(0, 1, 0, 0));
      do_run(2, '{9, 6, 0, 0}, 2, mk(0, 2, 1, 0));

      // start and table write during RUN must both be ignored
      exp_q.push_back(mk(1, 2, 0, 0));
      expCount = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      ch.outValid = 1'b1;
      ch.outData  = W'(3);
      step();
      ch.outValid = 1'b0;
      start    = 1'b1;
      expWrite = 1'b1;
      expIndex = 3'd1;
      expData  = W'(6);
      step();
      start    = 1'b0;
      expWrite = 1'b0;
      ch.outValid = 1'b1;
      ch.outData  = W'(5);
      step();
      ch.outValid = 1'b0;
      progDone = 1'b1;
      step();
      progDone = 1'b0;
      wait_finish("ignore_timeout");

      // progDone together with the last word: finished two edges later
      exp_q.push_back(mk(1, 2, 0, 0));
      expCount = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      ch.outValid = 1'b1;
      ch.outData  = W'(3);
      step();
      ch.outData  = W'(5);
      progDone = 1'b1;
      step();
      ch.outValid = 1'b0;
      progDone = 1'b0;
      chk("drain_outReady", int'(ch.outReady), 0);
      chk("drain_fin_d0", int'(finished), 0);
      step();
      chk("drain_fin_d1", int'(finished), 0);
      step();
      chk("drain_fin_d2", int'(finished), 1);
      step();

      // Empty run with expCount 0: finished one edge after progDone
      exp_q.push_back(mk(1, 0, 0, 0));
      expCount = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      progDone = 1'b1;
      step();
      progDone = 1'b0;
      chk("empty_fin_d0", int'(finished), 0);
      step();
      chk("empty_fin_d1", int'(finished), 1);
      step();

      // Reset mid-run clears outputs and the table
      expCount = 4'd2;
      start = 1'b1;
      step();
      start = 1'b0;
      ch.outValid = 1'b1;
      ch.outData  = W'(3);
      step();
      ch.outValid = 1'b0;
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      chk("mid_rst_outReady", int'(ch.outReady), 0);
      chk("mid_rst_finished", int'(finished), 0);
      chk("mid_rst_success", int'(success), 0);
      chk("mid_rst_received", int'(received), 0);
      chk("mid_rst_mismatch", int'(mismatch), 0);
      chk("mid_rst_mismatchIndex", int'(mismatchIndex), 0);
      do_run(1, '{0, 0, 0, 0}, 1, mk(1, 1, 0, 0));

      // Standalone FIFO: fill with pop blocked, then drain in order
      for (int i = 0; i < 4; i++) begin
         f_push  = 1'b1;
         f_wdata = W'(10 + i);
         step();
         chk("fifo_fill_count", int'(f_count), i + 1);
      end
      chk("fifo_full", int'(f_full), 1);
      f_wdata = W'(14);
      step();
      chk("fifo_full_block", int'(f_count), 4);
      chk("fifo_head0", int'(f_rdata), 10);
      f_wdata = W'(15);
      f_pop   = 1'b1;
      step();
      f_push = 1'b0;
      chk("fifo_full_pushpop", int'(f_count), 3);
      for (int v = 11; v <= 13; v++) begin
         chk("fifo_order", int'(f_rdata), v);
         step();
      end
      chk("fifo_empty", int'(f_empty), 1);
      step();
      chk("fifo_empty_pop", int'(f_count), 0);
      f_pop   = 1'b0;
      f_push  = 1'b1;
      f_wdata = W'(20);
      step();
      chk("fifo_wrap_head", int'(f_rdata), 20);
      f_wdata = W'(21);
      f_pop   = 1'b1;
      step();
      f_push = 1'b0;
      f_pop  = 1'b0;
      chk("fifo_pushpop_count", int'(f_count), 1);
      chk("fifo_wrap_next", int'(f_rdata), 21);

      step();
      chk("scoreboard_left", exp_q.size(), 0);
      chk("runs_seen", runs_done, 9);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
